// File: rtl/uart_rx.sv
// Oversampling 8N1 UART receiver: two-flop synchronizer, tick divider and a
// START/DATA/STOP FSM with registered, single-cycle done / framing-error pulses.
module uart_rx #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_rx_done,
  output logic                 o_framing_error,
  output logic                 o_busy
);

  localparam int DIV = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int DW  = $clog2(DIV);
  localparam int TW  = $clog2(OVERSAMPLE);
  localparam int BW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [TW-1:0] T_MID    = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_LAST   = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST   = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  logic                 sync1_q, rx_s_q;
  logic [DW-1:0]        div_q, div_d;
  state_t               state_q, state_d;
  logic [TW-1:0]        tcnt_q, tcnt_d;
  logic [BW-1:0]        bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 done_q, done_d;
  logic                 ferr_q, ferr_d;
  logic                 busy_q, busy_d;
  logic                 tick;

  // Next-state logic for the divider, the receive FSM and the output pulses.
  always_comb begin
    tick     = (div_q == DIV_LAST);
    div_d    = tick ? '0 : div_q + DW'(1);
    state_d  = state_q;
    tcnt_d   = tcnt_q;
    bcnt_d   = bcnt_q;
    shift_d  = shift_q;
    data_d   = data_q;
    done_d   = 1'b0;
    ferr_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d = S_START;
          tcnt_d  = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        // Confirm the start bit at its mid-point so short glitches fall back to IDLE.
        if (tick) begin
          if (tcnt_q == T_MID) begin
            tcnt_d = '0;
            if (!rx_s_q) begin
              state_d = S_DATA;
              bcnt_d  = '0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end else begin
          tcnt_d = tcnt_q;
        end
      end
      S_DATA: begin
        if (tick) begin
          if (tcnt_q == T_LAST) begin
            tcnt_d  = '0;
            shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
            if (bcnt_q == B_LAST) begin
              state_d = S_STOP;
            end else begin
              bcnt_d = bcnt_q + BW'(1);
            end
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end else begin
          tcnt_d = tcnt_q;
        end
      end
      S_STOP: begin
        if (tick) begin
          if (tcnt_q == T_LAST) begin
            tcnt_d  = '0;
            state_d = S_IDLE;
            if (rx_s_q) begin
              data_d = shift_q;
              done_d = 1'b1;
            end else begin
              ferr_d = 1'b1;
            end
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end else begin
          tcnt_d = tcnt_q;
        end
      end
      default: begin
        state_d = S_IDLE;
        tcnt_d  = '0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State registers with synchronous active-low reset; sync flops reset to line idle.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
      div_q   <= '0;
      state_q <= S_IDLE;
      tcnt_q  <= '0;
      bcnt_q  <= '0;
      shift_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync1_q <= i_rx;
      rx_s_q  <= sync1_q;
      div_q   <= div_d;
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      bcnt_q  <= bcnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
    end
  end

  assign o_data          = data_q;
  assign o_rx_done       = done_q;
  assign o_framing_error = ferr_q;
  assign o_busy          = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames push expected pulses, a negedge monitor
// pops and checks them whenever o_rx_done or o_framing_error fires.
module tb_uart_rx;

  localparam int BIT_CLKS = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] o_data;
  logic       o_rx_done, o_framing_error, o_busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct packed {
    logic       is_err;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int   done_cyc[$];
  exp_t mon_e;

  uart_rx #(
    .CLK_HZ(640), .BAUD(10), .OVERSAMPLE(16), .DATA_BITS(8)
  ) dut (
    .i_clock(clk), .i_reset(rst_n), .i_rx(rx),
    .o_data(o_data), .o_rx_done(o_rx_done),
    .o_framing_error(o_framing_error), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, want);
    end
  endtask

  // Monitor: every output pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && (o_rx_done || o_framing_error)) begin
      check("done_and_err_exclusive", 32'(o_rx_done && o_framing_error), 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_pulse", {30'd0, o_rx_done, o_framing_error}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("pulse_kind_is_err", 32'(o_framing_error), 32'(mon_e.is_err));
        check("pulse_data", 32'(o_data), 32'(mon_e.data));
      end
      if (o_rx_done) done_cyc.push_back(cyc);
    end
  end

  // stop_clks < BIT_CLKS shortens a low stop bit so no phantom start bit follows it.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int stop_clks);
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    rx = stop_bit;
    repeat (stop_clks) @(negedge clk);
    rx = 1'b1;
    repeat (BIT_CLKS - stop_clks) @(negedge clk);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s pending=%0d required=0", name, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nd;
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_data", 32'(o_data), 32'd0);
    check("reset_done", 32'(o_rx_done), 32'd0);
    check("reset_ferr", 32'(o_framing_error), 32'd0);
    check("reset_busy", 32'(o_busy), 32'd0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // 1: single good 0xFF
    sb.push_back('{1'b0, 8'hFF});
    send_frame(8'hFF, 1'b1, BIT_CLKS);
    drain("t1_drain");
    check("t1_data", 32'(o_data), 32'h0000_00FF);

    // 2: back-to-back 0xFF, 0xFF
    done_cyc.delete();
    sb.push_back('{1'b0, 8'hFF});
    sb.push_back('{1'b0, 8'hFF});
    send_frame(8'hFF, 1'b1, BIT_CLKS);
    send_frame(8'hFF, 1'b1, BIT_CLKS);
    drain("t2_drain");
    check("t2_done_count", 32'(done_cyc.size()), 32'd2);
    if (done_cyc.size() == 2) check("t2_spacing", 32'(done_cyc[1] - done_cyc[0]), 32'd640);
    check("t2_data", 32'(o_data), 32'h0000_00FF);

    // 3: 16-clock glitch is rejected, then 0x5A
    rx = 1'b0;
    repeat (16) @(negedge clk);
    rx = 1'b1;
    repeat (60) @(negedge clk);
    check("t3_busy_after_glitch", 32'(o_busy), 32'd0);
    sb.push_back('{1'b0, 8'h5A});
    send_frame(8'h5A, 1'b1, BIT_CLKS);
    drain("t3_drain");
    check("t3_data", 32'(o_data), 32'h0000_005A);

    // 4: good 0x12, then 0xA5 with a low stop bit
    sb.push_back('{1'b0, 8'h12});
    send_frame(8'h12, 1'b1, BIT_CLKS);
    sb.push_back('{1'b1, 8'h12});
    send_frame(8'hA5, 1'b0, 40);
    repeat (BIT_CLKS) @(negedge clk);
    drain("t4_drain");
    check("t4_data_held", 32'(o_data), 32'h0000_0012);
    check("t4_busy", 32'(o_busy), 32'd0);

    // 5: reset after 4 data bits of 0xC3, then 0x3C
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = (i == 0 || i == 1) ? 1'b1 : 1'b0;
      repeat (BIT_CLKS) @(negedge clk);
    end
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    check("t5_rst_data", 32'(o_data), 32'd0);
    check("t5_rst_done", 32'(o_rx_done), 32'd0);
    check("t5_rst_ferr", 32'(o_framing_error), 32'd0);
    check("t5_rst_busy", 32'(o_busy), 32'd0);
    rst_n = 1'b1;
    repeat (700) @(negedge clk);
    check("t5_data_after_idle", 32'(o_data), 32'd0);
    sb.push_back('{1'b0, 8'h3C});
    send_frame(8'h3C, 1'b1, BIT_CLKS);
    drain("t5_drain");
    check("t5_data", 32'(o_data), 32'h0000_003C);

    // 6: 0x7E then a long idle
    sb.push_back('{1'b0, 8'h7E});
    send_frame(8'h7E, 1'b1, BIT_CLKS);
    drain("t6_drain");
    nd = done_cyc.size();
    repeat (2000) @(negedge clk);
    check("t6_no_repulse", 32'(done_cyc.size()), 32'(nd));
    check("t6_data_held", 32'(o_data), 32'h0000_007E);
    check("t6_busy", 32'(o_busy), 32'd0);
    check("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
